touch_paddle_input: RTL and testbench

Front-end stage between the touch-panel controller and the Breakout game core. It converts raw 12-bit touch samples into the game's 320×240 coordinate space and smooths the X coordinate into `paddle_target_x`. It debounces the press state, classifies taps, and runs the game-control state machine. That state machine produces the `game_run` level and the one-cycle `new_game` pulse consumed by the game core.

---
 rtl/touch_paddle_input_if.sv | 22 ++
 rtl/touch_paddle_input.sv | 218 +++++++++++++++++++++
 tb/tb_touch_paddle_input.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/touch_paddle_input_if.sv
// Touch-sample and game-control signals between touch controller/game core and the paddle front-end.
interface touch_paddle_input_if;
  logic        touch_valid;
  logic        touch_pressed;
  logic [11:0] touch_raw_x;
  logic [11:0] touch_raw_y;
  logic        ball_lost;
  logic [8:0]  paddle_target_x;
  logic        touch_active;
  logic        game_run;
  logic        new_game;

  modport master (
    output touch_valid, touch_pressed, touch_raw_x, touch_raw_y, ball_lost,
    input  paddle_target_x, touch_active, game_run, new_game
  );

  modport slave (
    input  touch_valid, touch_pressed, touch_raw_x, touch_raw_y, ball_lost,
    output paddle_target_x, touch_active, game_run, new_game
  );
endinterface

// File: rtl/touch_paddle_input.sv
// Touch front-end for Breakout: scales raw samples, smooths paddle X, debounces the press,
// classifies taps and runs the game-control FSM.
module touch_paddle_input #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int GAME_W      = 320,
  parameter int GAME_H      = 240,
  parameter int RAW_X_MIN   = 200,
  parameter int RAW_X_MAX   = 3900,
  parameter int RAW_Y_MIN   = 200,
  parameter int RAW_Y_MAX   = 3900,
  parameter int AVG_LOG2    = 2,
  parameter int DEB_N       = 3,
  parameter int TAP_MAX_MS  = 300,
  parameter int HUD_H       = 24
) (
  input logic clk,
  input logic reset_n,
  touch_paddle_input_if.slave bus
);

  localparam int XW       = 9;
  localparam int YW       = $clog2(GAME_H);
  localparam int SW       = XW + AVG_LOG2;
  localparam int DEPTH    = 1 << AVG_LOG2;
  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW       = $clog2(TAP_MAX_MS + 2);
  localparam int DW       = $clog2(DEB_N + 1);

  localparam logic [15:0] SCALE_X = 16'((GAME_W * 65536) / (RAW_X_MAX - RAW_X_MIN));
  localparam logic [15:0] SCALE_Y = 16'((GAME_H * 65536) / (RAW_Y_MAX - RAW_Y_MIN));
  localparam logic [11:0] RX_MIN  = 12'(RAW_X_MIN);
  localparam logic [11:0] RX_MAX  = 12'(RAW_X_MAX);
  localparam logic [11:0] RY_MIN  = 12'(RAW_Y_MIN);
  localparam logic [11:0] RY_MAX  = 12'(RAW_Y_MAX);
  localparam logic [11:0] X_LIM   = 12'(GAME_W - 1);
  localparam logic [11:0] Y_LIM   = 12'(GAME_H - 1);

  function automatic logic [11:0] clamp_sub(input logic [11:0] raw, input logic [11:0] lo,
                                            input logic [11:0] hi);
    if (raw < lo)      return 12'd0;
    else if (raw > hi) return hi - lo;
    else               return raw - lo;
  endfunction

  function automatic logic [11:0] scale_sat(input logic [11:0] d, input logic [15:0] k,
                                            input logic [11:0] lim);
    logic [27:0] p;
    p = ({16'd0, d} * {12'd0, k}) >> 16;
    return (p > {16'd0, lim}) ? lim : p[11:0];
  endfunction

  // stage 1: clamp and offset; preload is pending until a pressed sample follows an unpressed one
  logic        s1_v, s1_pre, pre_pend;
  logic [11:0] s1_dx, s1_dy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v     <= 1'b0;
      s1_pre   <= 1'b0;
      pre_pend <= 1'b1;
      s1_dx    <= '0;
      s1_dy    <= '0;
    end else begin
      s1_v   <= bus.touch_valid & bus.touch_pressed;
      s1_pre <= pre_pend;
      s1_dx  <= clamp_sub(bus.touch_raw_x, RX_MIN, RX_MAX);
      s1_dy  <= clamp_sub(bus.touch_raw_y, RY_MIN, RY_MAX);
      if (bus.touch_valid) pre_pend <= ~bus.touch_pressed;
    end
  end

  logic          s2_v, s2_pre;
  logic [XW-1:0] s2_x;
  logic [YW-1:0] s2_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_v   <= 1'b0;
      s2_pre <= 1'b0;
      s2_x   <= '0;
      s2_y   <= '0;
    end else begin
      s2_v   <= s1_v;
      s2_pre <= s1_pre;
      s2_x   <= XW'(scale_sat(s1_dx, SCALE_X, X_LIM));
      s2_y   <= YW'(scale_sat(s1_dy, SCALE_Y, Y_LIM));
    end
  end

  // stage 3: moving average with running sum, then registered output
  logic [XW-1:0] win [DEPTH];
  logic [SW-1:0] sum;
  logic          s3_v;
  logic [XW-1:0] paddle;
  logic [YW-1:0] tap_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      sum    <= '0;
      s3_v   <= 1'b0;
      paddle <= XW'(GAME_W / 2);
      tap_y  <= '0;
    end else begin
      s3_v <= s2_v;
      if (s2_v) begin
        if (s2_pre) begin
          for (int i = 0; i < DEPTH; i++) win[i] <= s2_x;
          sum   <= SW'(s2_x) << AVG_LOG2;
          tap_y <= s2_y;
        end else begin
          win[0] <= s2_x;
          for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
          sum <= sum + SW'(s2_x) - SW'(win[DEPTH-1]);
        end
      end
      if (s3_v) paddle <= XW'(sum >> AVG_LOG2);
    end
  end

  logic [TW-1:0] tick_cnt;
  logic          tick;
  assign tick = (tick_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= TW'(TICK_DIV - 1);
    else if (tick) tick_cnt <= TW'(TICK_DIV - 1);
    else           tick_cnt <= tick_cnt - TW'(1);
  end

  logic          active, active_d, deb_flip, tap_evt, hud_tap;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] press_tmr;

  assign deb_flip = bus.touch_valid && (bus.touch_pressed != active) &&
                    (deb_cnt == DW'(DEB_N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 1'b0;
      active_d  <= 1'b0;
      deb_cnt   <= '0;
      press_tmr <= '0;
      tap_evt   <= 1'b0;
      hud_tap   <= 1'b0;
    end else begin
      active_d <= active;
      if (bus.touch_valid) begin
        if (deb_flip) begin
          active  <= ~active;
          deb_cnt <= '0;
        end else if (bus.touch_pressed != active) begin
          deb_cnt <= deb_cnt + DW'(1);
        end else begin
          deb_cnt <= '0;
        end
      end
      if (deb_flip && !active)
        press_tmr <= '0;
      else if (active && tick && press_tmr != PW'(TAP_MAX_MS + 1))
        press_tmr <= press_tmr + PW'(1);
      tap_evt <= active_d && !active && (press_tmr <= PW'(TAP_MAX_MS));
      hud_tap <= (tap_y < YW'(HUD_H));
    end
  end

  // state    | meaning
  // IDLE     | waiting for the first tap after reset
  // PLAYING  | game core running (game_run = 1)
  // PAUSED   | HUD tap paused the game
  // OVER     | ball lost, waiting for a tap to restart
  typedef enum logic [1:0] {ST_IDLE, ST_PLAYING, ST_PAUSED, ST_OVER} state_t;

  state_t state, state_nxt;
  logic   ball_lost_q, bl_rise, new_game_q, new_game_nxt;

  assign bl_rise = bus.ball_lost & ~ball_lost_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ball_lost_q <= 1'b0;
      new_game_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      ball_lost_q <= bus.ball_lost;
      new_game_q  <= new_game_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    new_game_nxt = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (tap_evt) begin
          new_game_nxt = 1'b1;
          state_nxt    = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (bl_rise)                 state_nxt = ST_OVER;
        else if (tap_evt && hud_tap) state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (tap_evt && hud_tap) state_nxt = ST_PLAYING;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.paddle_target_x = paddle;
  assign bus.touch_active    = active;
  assign bus.game_run        = (state == ST_PLAYING);
  assign bus.new_game        = new_game_q;

endmodule

// File: tb/tb_touch_paddle_input.sv
// Bench for touch_paddle_input: random touch traffic against a sample-level model, plus tap/FSM sequences.
module tb_touch_paddle_input;
  localparam int CLK_HZ     = 10_000;
  localparam int CYC_PER_MS = CLK_HZ / 1000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  touch_paddle_input_if tb_if();

  touch_paddle_input #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (tb_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: per-sample behaviour, output seen three edges after the sample
  int win [4];
  bit m_pre;
  int m_pad, m_act, m_cnt, exp_pad;
  int hist [$];

  function automatic int scale(input int raw, input int lo, input int hi, input int w);
    int c, r;
    c = (raw < lo) ? lo : ((raw > hi) ? hi : raw);
    r = ((c - lo) * ((w * 65536) / (hi - lo))) / 65536;
    return (r > w - 1) ? w - 1 : r;
  endfunction

  task automatic model_reset();
    foreach (win[i]) win[i] = 0;
    m_pre = 1'b1;
    m_pad = 160;
    m_act = 0;
    m_cnt = 0;
    hist = {160, 160, 160};
    exp_pad = 160;
  endtask

  task automatic model_step();
    int x, s;
    if (tb_if.touch_valid) begin
      if (tb_if.touch_pressed) begin
        x = scale(int'(tb_if.touch_raw_x), 200, 3900, 320);
        if (m_pre) foreach (win[i]) win[i] = x;
        else begin
          for (int i = 3; i > 0; i--) win[i] = win[i-1];
          win[0] = x;
        end
        m_pre = 1'b0;
        s = 0;
        foreach (win[i]) s += win[i];
        m_pad = s / 4;
      end else begin
        m_pre = 1'b1;
      end
      if (int'(tb_if.touch_pressed) != m_act) begin
        m_cnt++;
        if (m_cnt == 3) begin
          m_act = 1 - m_act;
          m_cnt = 0;
        end
      end else begin
        m_cnt = 0;
      end
    end
    hist.push_back(m_pad);
    exp_pad = hist.pop_front();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else model_step();
    chk("paddle", int'(tb_if.paddle_target_x), exp_pad);
    chk("active", int'(tb_if.touch_active), m_act);
  endtask

  task automatic drv(input bit v, input bit p, input int rx, input int ry);
    tb_if.touch_valid   = v;
    tb_if.touch_pressed = p;
    tb_if.touch_raw_x   = 12'(rx);
    tb_if.touch_raw_y   = 12'(ry);
  endtask

  task automatic tap(input int ry, input int ms, input bit raise_bl,
                     input int exp_ng, input int exp_run);
    for (int i = 0; i < ms * CYC_PER_MS; i++) begin
      drv(1, 1, 2050, ry);
      cyc();
    end
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 2050, ry);
      cyc();
    end
    drv(0, 0, 0, 0);
    cyc();
    chk("ng_early", int'(tb_if.new_game), 0);
    if (raise_bl) tb_if.ball_lost = 1'b1;
    cyc();
    chk("ng_pulse", int'(tb_if.new_game), exp_ng);
    chk("run_after_tap", int'(tb_if.game_run), exp_run);
    cyc();
    chk("ng_width", int'(tb_if.new_game), 0);
    chk("run_hold", int'(tb_if.game_run), exp_run);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat [6];
    int pexp [6];
    int obs [11];
    bit mode, p;
    int sel, rx;

    pat  = '{1, 1, 0, 1, 1, 1};
    pexp = '{0, 0, 0, 0, 0, 1};
    drv(0, 0, 0, 0);
    tb_if.ball_lost = 1'b0;
    model_reset();

    repeat (2) cyc();
    chk("rst_run", int'(tb_if.game_run), 0);
    chk("rst_ng", int'(tb_if.new_game), 0);
    reset_n = 1'b1;
    cyc();
    chk("post_rst_run", int'(tb_if.game_run), 0);

    for (int i = 0; i < 6; i++) begin
      drv(1, pat[i][0], 2050, 3000);
      cyc();
      chk("deb_rise", int'(tb_if.touch_active), pexp[i]);
    end
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 2050, 3000);
      cyc();
      chk("deb_fall", int'(tb_if.touch_active), (i == 2) ? 0 : 1);
    end

    for (int k = 0; k < 11; k++) begin
      if (k < 4)      drv(1, 1, 200, 1000);
      else if (k < 8) drv(1, 1, 3900, 1000);
      else            drv(0, 0, 0, 0);
      cyc();
      obs[k] = int'(tb_if.paddle_target_x);
    end
    chk("flt_min", obs[3], 0);
    chk("flt_ramp1", obs[7], 79);
    chk("flt_ramp2", obs[8], 159);
    chk("flt_ramp3", obs[9], 239);
    chk("flt_ramp4", obs[10], 319);

    drv(1, 0, 0, 0);
    cyc();
    drv(1, 1, 2050, 1000);
    cyc();
    drv(0, 0, 0, 0);
    cyc();
    cyc();
    chk("lat_early", int'(tb_if.paddle_target_x), 319);
    cyc();
    chk("preload_mid", int'(tb_if.paddle_target_x), 159);

    drv(1, 0, 0, 0);
    cyc();
    drv(1, 1, 4095, 1000);
    cyc();
    drv(0, 0, 0, 0);
    repeat (3) cyc();
    chk("sat_max", int'(tb_if.paddle_target_x), 319);

    mode = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      p = mode;
      if ($urandom_range(0, 7) == 0) p = ~p;
      sel = $urandom_range(0, 9);
      if (sel == 0)      rx = $urandom_range(0, 199);
      else if (sel == 1) rx = $urandom_range(3900, 4095);
      else               rx = $urandom_range(0, 4095);
      drv($urandom_range(0, 3) != 0, p, rx, $urandom_range(0, 4095));
      cyc();
    end

    for (int i = 0; i < 10; i++) begin
      drv(1, 1, 1500, 2000);
      cyc();
    end
    chk("pre_rst_active", int'(tb_if.touch_active), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_pad", int'(tb_if.paddle_target_x), 160);
    chk("rst_async_act", int'(tb_if.touch_active), 0);
    chk("rst_async_run", int'(tb_if.game_run), 0);
    chk("rst_async_ng", int'(tb_if.new_game), 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    drv(1, 1, 3900, 2000);
    repeat (4) cyc();
    chk("rst_preload", int'(tb_if.paddle_target_x), 319);
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 0);
      cyc();
    end
    drv(0, 0, 0, 0);
    repeat (3) cyc();
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    chk("idle_run", int'(tb_if.game_run), 0);

    tap(3000, 100, 0, 1, 1);
    tap(300, 100, 0, 0, 0);
    tb_if.ball_lost = 1'b1;
    cyc();
    tb_if.ball_lost = 1'b0;
    cyc();
    chk("paused_bl", int'(tb_if.game_run), 0);
    tap(300, 100, 0, 0, 1);
    tap(3000, 100, 0, 0, 1);
    tap(300, 400, 0, 0, 1);

    tb_if.ball_lost = 1'b1;
    cyc();
    chk("over", int'(tb_if.game_run), 0);
    repeat (5) cyc();
    chk("over_hold", int'(tb_if.game_run), 0);
    tap(3000, 100, 0, 1, 1);
    repeat (20) cyc();
    chk("run_stale_bl", int'(tb_if.game_run), 1);
    chk("no_extra_ng", int'(tb_if.new_game), 0);

    tb_if.ball_lost = 1'b0;
    repeat (3) cyc();
    tap(300, 100, 1, 0, 0);
    repeat (3) cyc();
    chk("simul_over", int'(tb_if.game_run), 0);
    tap(3000, 100, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
